max_pool_window: RTL

MAX_POOL_WINDOW -- requirements
Module: max_pool_window

---
 rtl/max_pool_pkg.sv | 37 +++
 rtl/max_pool_lane.sv | 104 ++++++++++
 rtl/max_pool_window.sv | 118 +++++++++++
 3 files changed

// File: rtl/max_pool_pkg.sv
// ---------------------------------------------------------------------------
// max_pool_pkg
//   Shared helpers for the max-pooling window block.
//   - idx_width(): width of the in-window beat index, max(1, clog2(window)).
//   - greater():   strict greater-than on a BITWIDTH-wide value that is
//                  carried zero-extended in a 64-bit container. It supports
//                  unsigned and two's-complement interpretation.
//   Elements are limited to 64 bits by the container width.
// ---------------------------------------------------------------------------
package max_pool_pkg;

  localparam int MAX_BITWIDTH = 64;

  // Width of the beat counter / argmax index for a given window length.
  function automatic int idx_width(input int window);
    int w;
    w = $clog2(window);
    return (w < 1) ? 1 : w;
  endfunction

  // Strict a > b over the low 'width' bits. The operands must be
  // zero-extended. In signed mode the sign bit is inverted on both operands.
  // This maps two's-complement order onto unsigned order, so one unsigned
  // compare handles both modes without widening.
  function automatic logic greater(input logic [MAX_BITWIDTH-1:0] a,
                                   input logic [MAX_BITWIDTH-1:0] b,
                                   input int                      width,
                                   input logic                    is_signed);
    logic [MAX_BITWIDTH-1:0] sign_bit;
    sign_bit = {{(MAX_BITWIDTH-1){1'b0}}, 1'b1} << (width - 1);
    if (is_signed) begin
      return (a ^ sign_bit) > (b ^ sign_bit);
    end
    return a > b;
  endfunction

endpackage : max_pool_pkg

// File: rtl/max_pool_lane.sv
// ---------------------------------------------------------------------------
// max_pool_lane
//   One pooling lane: a running-maximum accumulator and the compare. When
//   MAX_POOL_ARGMAX_EN is defined, the lane also tracks the beat index that
//   supplied the maximum. The lane registers the finished window maximum
//   into its slice of the output when the top level signals the final beat.
//
//   Ports
//     clk, rst   : clock, synchronous active-high reset
//     clear      : discard the partial window
//     beat       : an input beat is accepted this cycle
//     first      : the accepted beat is the first of its window (cnt == 0)
//     load_out   : the accepted beat is the last of its window
//     cnt        : current beat index (argmax builds only)
//     in_data    : this lane's element of the accepted beat
//     out_data   : registered window maximum
//     out_idx    : registered argmax index (argmax builds only)
//
//   Optional feature macro: MAX_POOL_ARGMAX_EN
// ---------------------------------------------------------------------------
module max_pool_lane
  import max_pool_pkg::*;
#(
  parameter int BITWIDTH = 8,
  parameter int SIGNED   = 0
`ifdef MAX_POOL_ARGMAX_EN
  ,
  parameter int IDX_W    = 2
`endif
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clear,
  input  logic                beat,
  input  logic                first,
  input  logic                load_out,
`ifdef MAX_POOL_ARGMAX_EN
  input  logic [IDX_W-1:0]    cnt,
  output logic [IDX_W-1:0]    out_idx,
`endif
  input  logic [BITWIDTH-1:0] in_data,
  output logic [BITWIDTH-1:0] out_data
);

  logic [BITWIDTH-1:0] acc;
  logic [BITWIDTH-1:0] next_max;
  logic                take;

  // The first beat of a window always wins. Later beats win only when they
  // are strictly greater, so ties keep the earlier value and its index.
  // NOTE: every signal assigned in always_comb gets a value on every path;
  // otherwise synthesis infers a latch.
  always_comb begin
    take     = first || greater(MAX_BITWIDTH'(in_data), MAX_BITWIDTH'(acc),
                                BITWIDTH, SIGNED != 0);
    next_max = take ? in_data : acc;
  end

`ifdef MAX_POOL_ARGMAX_EN
  logic [IDX_W-1:0] acc_idx;
  logic [IDX_W-1:0] next_idx;

  always_comb begin
    next_idx = take ? cnt : acc_idx;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_idx <= '0;
      out_idx <= '0;
    end else begin
      if (clear) begin
        acc_idx <= '0;
      end else if (beat) begin
        acc_idx <= next_idx;
      end
      if (load_out) begin
        out_idx <= next_idx;
      end
    end
  end
`endif

  // NOTE: sequential state uses non-blocking assignments only. Then every
  // flop samples pre-edge values, whatever the order of the statements.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc      <= '0;
      out_data <= '0;
    end else begin
      if (clear) begin
        acc <= '0;
      end else if (beat) begin
        acc <= next_max;
      end
      // load_out is only ever asserted together with beat, so next_max
      // already includes the final beat of the window.
      if (load_out) begin
        out_data <= next_max;
      end
    end
  end

endmodule : max_pool_lane

// File: rtl/max_pool_window.sv
// ---------------------------------------------------------------------------
// max_pool_window
//   Streaming max-pool over WINDOW consecutive beats. Each of the CHANNELS
//   lanes of BITWIDTH bits is pooled on its own. The block emits one result per
//   window with a latency of one cycle. Non-final beats are accepted while
//   the output is stalled. Only the final beat of a window waits for the
//   output register to free up.
//
//   Parameters
//     BITWIDTH : element width (<= 64)
//     CHANNELS : number of lanes
//     WINDOW   : beats per window, 1..256
//     SIGNED   : 0 = unsigned compare, 1 = two's-complement compare
//
//   Ports
//     clk, rst            : clock, synchronous active-high reset
//     clear               : abort the partial window (the output is untouched)
//     in_valid/in_ready   : input handshake
//     in_data             : lane c at [c*BITWIDTH +: BITWIDTH]
//     out_valid/out_ready : output handshake
//     out_data            : per-lane window maxima, same packing as in_data
//     out_idx             : per-lane argmax beat index (argmax builds only)
//
//   Optional feature macro: MAX_POOL_ARGMAX_EN adds out_idx and the index
//   tracking. Without it, the block has no index logic at all.
// ---------------------------------------------------------------------------
module max_pool_window
  import max_pool_pkg::*;
#(
  parameter  int BITWIDTH = 8,
  parameter  int CHANNELS = 4,
  parameter  int WINDOW   = 4,
  parameter  int SIGNED   = 0,
  localparam int IDX_W    = idx_width(WINDOW)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clear,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [CHANNELS*BITWIDTH-1:0] in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [CHANNELS*BITWIDTH-1:0] out_data
`ifdef MAX_POOL_ARGMAX_EN
  ,
  output logic [CHANNELS*IDX_W-1:0]    out_idx
`endif
);

  localparam logic [IDX_W-1:0] LAST_CNT = IDX_W'(WINDOW - 1);

  logic [IDX_W-1:0] cnt;
  logic             first;
  logic             last;
  logic             accept;
  logic             final_beat;

  // Only the final beat needs the output register, so only the final beat
  // is back-pressured by a stalled output. An output transfer in the same
  // cycle frees the register, which allows a back-to-back result.
  always_comb begin
    first      = (cnt == '0);
    last       = (cnt == LAST_CNT);
    in_ready   = !rst && !clear && !(out_valid && !out_ready && last);
    accept     = in_valid && in_ready;
    final_beat = accept && last;
  end

  // Beat counter. It wraps after the last beat of the window and restarts
  // on clear. With WINDOW == 1 it stays at zero, so every beat is final.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (accept) begin
      cnt <= last ? '0 : cnt + 1'b1;
    end
  end

  // out_valid is set by a new result and cleared by a completed transfer.
  // A new result wins over a transfer completing in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
    end else if (final_beat) begin
      out_valid <= 1'b1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
    max_pool_lane #(
      .BITWIDTH (BITWIDTH),
      .SIGNED   (SIGNED)
`ifdef MAX_POOL_ARGMAX_EN
      ,
      .IDX_W    (IDX_W)
`endif
    ) u_lane (
      .clk      (clk),
      .rst      (rst),
      .clear    (clear),
      .beat     (accept),
      .first    (first),
      .load_out (final_beat),
`ifdef MAX_POOL_ARGMAX_EN
      .cnt      (cnt),
      .out_idx  (out_idx[c*IDX_W +: IDX_W]),
`endif
      .in_data  (in_data[c*BITWIDTH +: BITWIDTH]),
      .out_data (out_data[c*BITWIDTH +: BITWIDTH])
    );
  end

endmodule : max_pool_window
